// File: rtl/gaus_cordic_sched_if.sv
// Request, ROM and result bundle of the shared cosine-ROM scheduler.
// slave = scheduler side, master = requesters / ROM / result consumer side.
interface gaus_cordic_sched_if #(
   parameter int NREQ = 2,
   parameter int ID_W = 3
);
   logic [NREQ-1:0]    ireq_val;
   logic [NREQ*11-1:0] ireq_phase;
   logic [NREQ-1:0]    oreq_rdy;
   logic               otab_clkena;
   logic [8:0]         otab_cos_addr;
   logic [8:0]         otab_sin_addr;
   logic [17:0]        itab_cos;
   logic [17:0]        itab_sin;
   logic               oval;
   logic [ID_W-1:0]    oid;
   logic signed [18:0] ocos;
   logic signed [18:0] osin;
   logic               iready;

   modport slave (
      input  ireq_val, ireq_phase, itab_cos, itab_sin, iready,
      output oreq_rdy, otab_clkena, otab_cos_addr, otab_sin_addr,
             oval, oid, ocos, osin
   );

   modport master (
      output ireq_val, ireq_phase, itab_cos, itab_sin, iready,
      input  oreq_rdy, otab_clkena, otab_cos_addr, otab_sin_addr,
             oval, oid, ocos, osin
   );
endinterface

// File: rtl/gaus_cordic_sched.sv
// Round-robin scheduler sharing a 2-cycle quarter-wave cosine ROM between NREQ phase requesters.
// Optional grant/stall statistics counters: define GAUS_CORDIC_SCHED_STAT_EN.
module gaus_cordic_sched #(
   parameter int NREQ = 2,
   parameter int ID_W = 3
) (
   input  logic                iclk,
   input  logic                ireset,
   input  logic                iclkena,
`ifdef GAUS_CORDIC_SCHED_STAT_EN
   output logic [NREQ*16-1:0]  ostat_grant,
   output logic [15:0]         ostat_stall,
`endif
   gaus_cordic_sched_if.slave  bus
);

   logic            en;
   logic            accept;
   logic            found;
   logic [ID_W-1:0] last;
   logic [ID_W-1:0] grant;
   logic [10:0]     phase;
   logic [NREQ-1:0] rdy;

   logic            s0_val, s1_val, s2_val;
   logic [ID_W-1:0] s0_id, s1_id, s2_id;
   logic [1:0]      s0_q, s1_q, s2_q;
   logic [18:0]     cext, sext;

   // Two scans: first requesters above the last winner, then wrap to the rest.
   always_comb begin
      en    = iclkena & (~bus.oval | bus.iready);
      found = 1'b0;
      grant = last;
      phase = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && bus.ireq_val[i] && (ID_W'(i) > last)) begin
            found = 1'b1;
            grant = ID_W'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && bus.ireq_val[i] && (ID_W'(i) <= last)) begin
            found = 1'b1;
            grant = ID_W'(i);
         end
      end
      accept = en & found;
      for (int i = 0; i < NREQ; i++) begin
         rdy[i] = accept && (grant == ID_W'(i));
         if (grant == ID_W'(i))
            phase = bus.ireq_phase[11*i +: 11];
      end
      bus.oreq_rdy    = rdy;
      bus.otab_clkena = en;
      cext = {1'b0, bus.itab_cos};
      sext = {1'b0, bus.itab_sin};
   end

   // Odd quadrants swap the folded cos/sin addresses; 511-k is the 9-bit complement of k.
   always_ff @(posedge iclk) begin
      if (ireset) begin
         last              <= ID_W'(NREQ - 1);
         s0_val            <= 1'b0;
         s1_val            <= 1'b0;
         s2_val            <= 1'b0;
         s0_id             <= '0;
         s1_id             <= '0;
         s2_id             <= '0;
         s0_q              <= '0;
         s1_q              <= '0;
         s2_q              <= '0;
         bus.otab_cos_addr <= '0;
         bus.otab_sin_addr <= '0;
         bus.oval          <= 1'b0;
         bus.oid           <= '0;
         bus.ocos          <= '0;
         bus.osin          <= '0;
      end else if (en) begin
         if (accept) begin
            last              <= grant;
            s0_id             <= grant;
            s0_q              <= phase[10:9];
            bus.otab_cos_addr <= phase[9] ? ~phase[8:0] : phase[8:0];
            bus.otab_sin_addr <= phase[9] ? phase[8:0] : ~phase[8:0];
         end
         s0_val   <= accept;
         s1_val   <= s0_val;
         s1_id    <= s0_id;
         s1_q     <= s0_q;
         s2_val   <= s1_val;
         s2_id    <= s1_id;
         s2_q     <= s1_q;
         bus.oval <= s2_val;
         bus.oid  <= s2_id;
         // cos is negative in quadrants 1 and 2, sin in quadrants 2 and 3.
         bus.ocos <= (s2_q[1] ^ s2_q[0]) ? -cext : cext;
         bus.osin <= s2_q[1] ? -sext : sext;
      end
   end

`ifdef GAUS_CORDIC_SCHED_STAT_EN
   logic [NREQ-1:0][15:0] grant_cnt;
   logic [15:0]           stall_cnt;

   always_ff @(posedge iclk) begin
      if (ireset) begin
         grant_cnt <= '0;
         stall_cnt <= '0;
      end else if (iclkena) begin
         for (int i = 0; i < NREQ; i++) begin
            if (rdy[i] && (grant_cnt[i] != 16'hFFFF))
               grant_cnt[i] <= grant_cnt[i] + 16'd1;
         end
         if (bus.oval && !bus.iready && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign ostat_grant = grant_cnt;
   assign ostat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_gaus_cordic_sched.sv
// Directed self-checking bench for gaus_cordic_sched with a 2-cycle clock-enabled ROM model.
// Statistics checks are compiled in when GAUS_CORDIC_SCHED_STAT_EN is defined.
module tb_gaus_cordic_sched;
   localparam int NREQ = 2;
   localparam int ID_W = 3;
   localparam logic signed [18:0] POS = 19'sd131071;
   localparam logic signed [18:0] NEG = -19'sd131071;

   logic iclk = 1'b0;
   logic ireset = 1'b0;
   logic iclkena = 1'b1;
`ifdef GAUS_CORDIC_SCHED_STAT_EN
   logic [NREQ*16-1:0] ostat_grant;
   logic [15:0]        ostat_stall;
`endif

   gaus_cordic_sched_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

   gaus_cordic_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
      .iclk    (iclk),
      .ireset  (ireset),
      .iclkena (iclkena),
`ifdef GAUS_CORDIC_SCHED_STAT_EN
      .ostat_grant (ostat_grant),
      .ostat_stall (ostat_stall),
`endif
      .bus     (bus.slave)
   );

   always #5 iclk = ~iclk;

   // Linear table keeps the two endpoints the checks rely on: T[0]=131071, T[511]=0.
   logic [17:0] rom [512];
   logic [17:0] rc1, rs1;
   initial begin
      for (int i = 0; i < 512; i++) rom[i] = 18'((longint'(511 - i) * 131071) / 511);
      rc1 = '0;
      rs1 = '0;
      bus.itab_cos = '0;
      bus.itab_sin = '0;
   end
   always @(posedge iclk) begin
      if (bus.otab_clkena) begin
         rc1 <= rom[bus.otab_cos_addr];
         rs1 <= rom[bus.otab_sin_addr];
         bus.itab_cos <= rc1;
         bus.itab_sin <= rs1;
      end
   end

   // Transfer/grant log sampled at the falling edge, when inputs are stable.
   int cyc = 0;
   int ovalSeen = 0;
   int grantQ[$];
   int outIdQ[$];
   int outCycQ[$];
   logic signed [18:0] outCosQ[$];
   logic signed [18:0] outSinQ[$];
   always @(posedge iclk) cyc <= cyc + 1;
   always @(negedge iclk) begin
      if (bus.oval) ovalSeen++;
      if (!ireset && iclkena && bus.oval && bus.iready) begin
         outIdQ.push_back(int'(bus.oid));
         outCosQ.push_back(bus.ocos);
         outSinQ.push_back(bus.osin);
         outCycQ.push_back(cyc);
      end
      for (int i = 0; i < NREQ; i++)
         if (!ireset && bus.oreq_rdy[i]) grantQ.push_back(i);
   end

   int compared = 0;
   int mismatched = 0;

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] val, input logic [10:0] p0, input logic [10:0] p1);
      bus.ireq_val   = val;
      bus.ireq_phase = {p1, p0};
      #1;
   endtask

   task automatic clearLogs();
      grantQ.delete();
      outIdQ.delete();
      outCosQ.delete();
      outSinQ.delete();
      outCycQ.delete();
      ovalSeen = 0;
   endtask

   task automatic doReset();
      ireset = 1'b1;
      tick();
      tick();
      ireset = 1'b0;
   endtask

   task automatic test_reset();
      applyStimulus(2'b00, 11'd0, 11'd0);
      doReset();
      compared++; if (bus.oval !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_oval: got %0b want 0", bus.oval); end
      compared++; if (bus.oid !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_oid: got %0d want 0", bus.oid); end
      compared++; if (bus.ocos !== 19'sd0 || bus.osin !== 19'sd0) begin mismatched++; $display("[TB] FAIL reset_data: got %0d/%0d want 0/0", bus.ocos, bus.osin); end
      compared++; if (bus.otab_cos_addr !== 9'd0 || bus.otab_sin_addr !== 9'd0) begin mismatched++; $display("[TB] FAIL reset_addr: got %0d/%0d want 0/0", bus.otab_cos_addr, bus.otab_sin_addr); end
      compared++; if (bus.otab_clkena !== 1'b1 || bus.oreq_rdy !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_ctrl: clkena %0b rdy %0b want 1 00", bus.otab_clkena, bus.oreq_rdy); end
   endtask

   task automatic test_single();
      applyStimulus(2'b01, 11'h000, 11'h000);
      compared++; if (bus.oreq_rdy !== 2'b01) begin mismatched++; $display("[TB] FAIL single_rdy: got %b want 01", bus.oreq_rdy); end
      tick();
      applyStimulus(2'b00, 11'h000, 11'h000);
      compared++; if (bus.otab_cos_addr !== 9'd0 || bus.otab_sin_addr !== 9'd511) begin mismatched++; $display("[TB] FAIL single_addr: got %0d/%0d want 0/511", bus.otab_cos_addr, bus.otab_sin_addr); end
      tick();
      tick();
      compared++; if (bus.oval !== 1'b0) begin mismatched++; $display("[TB] FAIL single_early: oval %0b want 0 at cycle 3", bus.oval); end
      tick();
      compared++; if (bus.oval !== 1'b1 || bus.oid !== 3'd0) begin mismatched++; $display("[TB] FAIL single_latency: oval %0b oid %0d want 1 0", bus.oval, bus.oid); end
      compared++; if (bus.ocos !== POS || bus.osin !== 19'sd0) begin mismatched++; $display("[TB] FAIL single_data: got %0d/%0d want 131071/0", bus.ocos, bus.osin); end
   endtask

   task automatic test_quadrant();
      logic [10:0]        ph [4];
      logic signed [18:0] ec [4];
      logic signed [18:0] es [4];
      ph = '{11'h200, 11'h400, 11'h600, 11'h7FF};
      ec = '{19'sd0, NEG, 19'sd0, POS};
      es = '{POS, 19'sd0, NEG, 19'sd0};
      for (int n = 0; n < 4; n++) begin
         applyStimulus(2'b01, ph[n], 11'h000);
         tick();
         applyStimulus(2'b00, 11'h000, 11'h000);
         repeat (3) tick();
         compared++;
         if (bus.oval !== 1'b1 || bus.ocos !== ec[n] || bus.osin !== es[n]) begin
            mismatched++;
            $display("[TB] FAIL quadrant_%h: got val %0b %0d/%0d want 1 %0d/%0d", ph[n], bus.oval, bus.ocos, bus.osin, ec[n], es[n]);
         end
      end
   endtask

   task automatic test_back_to_back();
      doReset();
      clearLogs();
      applyStimulus(2'b11, 11'h000, 11'h400);
      repeat (8) tick();
      applyStimulus(2'b00, 11'h000, 11'h000);
      repeat (8) tick();
      compared++; if (grantQ.size() != 8 || outIdQ.size() != 8) begin mismatched++; $display("[TB] FAIL b2b_count: grants %0d results %0d want 8 8", grantQ.size(), outIdQ.size()); end
      for (int k = 0; k < 8 && k < grantQ.size() && k < outIdQ.size(); k++) begin
         compared++; if (grantQ[k] != k % 2) begin mismatched++; $display("[TB] FAIL b2b_grant[%0d]: got %0d want %0d", k, grantQ[k], k % 2); end
         compared++;
         if (outIdQ[k] != k % 2 || outCosQ[k] !== ((k % 2) ? NEG : POS) || outSinQ[k] !== 19'sd0 || outCycQ[k] != outCycQ[0] + k) begin
            mismatched++;
            $display("[TB] FAIL b2b_result[%0d]: id %0d cos %0d sin %0d dcyc %0d want id %0d dcyc %0d", k, outIdQ[k], outCosQ[k], outSinQ[k], outCycQ[k] - outCycQ[0], k % 2, k);
         end
      end
   endtask

   task automatic test_stall();
      doReset();
      clearLogs();
      applyStimulus(2'b01, 11'h000, 11'h000);
      tick();
      applyStimulus(2'b01, 11'h200, 11'h000);
      tick();
      applyStimulus(2'b01, 11'h400, 11'h000);
      tick();
      bus.iready = 1'b0;
      applyStimulus(2'b00, 11'h000, 11'h000);
      tick();
      applyStimulus(2'b10, 11'h000, 11'h400);
      for (int n = 0; n < 5; n++) begin
         compared++;
         if (bus.oval !== 1'b1 || bus.ocos !== POS || bus.osin !== 19'sd0 || bus.otab_clkena !== 1'b0 || bus.oreq_rdy !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL stall_hold[%0d]: val %0b %0d/%0d clkena %0b rdy %b want 1 131071/0 0 00", n, bus.oval, bus.ocos, bus.osin, bus.otab_clkena, bus.oreq_rdy);
         end
         tick();
      end
      bus.iready = 1'b1;
      applyStimulus(2'b00, 11'h000, 11'h000);
      repeat (6) tick();
      compared++;
      if (outCosQ.size() != 3) begin
         mismatched++;
         $display("[TB] FAIL stall_count: got %0d results want 3", outCosQ.size());
      end else if (outCosQ[0] !== POS || outSinQ[0] !== 19'sd0 || outCosQ[1] !== 19'sd0 || outSinQ[1] !== POS || outCosQ[2] !== NEG || outSinQ[2] !== 19'sd0) begin
         mismatched++;
         $display("[TB] FAIL stall_order: got %0d/%0d %0d/%0d %0d/%0d", outCosQ[0], outSinQ[0], outCosQ[1], outSinQ[1], outCosQ[2], outSinQ[2]);
      end
`ifdef GAUS_CORDIC_SCHED_STAT_EN
      compared++; if (ostat_grant !== {16'd0, 16'd3} || ostat_stall !== 16'd5) begin mismatched++; $display("[TB] FAIL stall_stats: grant %h stall %0d want 00000003 5", ostat_grant, ostat_stall); end
`endif
   endtask

   task automatic test_reset_mid();
      doReset();
      for (int n = 0; n < 3; n++) begin
         applyStimulus(2'b01, 11'h000, 11'h000);
         tick();
      end
      applyStimulus(2'b00, 11'h000, 11'h000);
      tick();
      ireset = 1'b1;
      tick();
      ireset = 1'b0;
      clearLogs();
      repeat (8) tick();
      compared++; if (ovalSeen != 0 || outCosQ.size() != 0) begin mismatched++; $display("[TB] FAIL resetmid_flush: oval cycles %0d results %0d want 0 0", ovalSeen, outCosQ.size()); end
      applyStimulus(2'b11, 11'h000, 11'h000);
      compared++; if (bus.oreq_rdy !== 2'b01) begin mismatched++; $display("[TB] FAIL resetmid_grant: got %b want 01", bus.oreq_rdy); end
      applyStimulus(2'b00, 11'h000, 11'h000);
   endtask

   task automatic test_clkena();
      logic [10:0] ph [4];
      ph = '{11'h000, 11'h200, 11'h400, 11'h600};
      doReset();
      clearLogs();
      for (int n = 0; n < 4; n++) begin
         applyStimulus(2'b01, ph[n], 11'h000);
         tick();
      end
      iclkena = 1'b0;
      applyStimulus(2'b01, 11'h000, 11'h000);
      for (int n = 0; n < 3; n++) begin
         compared++;
         if (bus.oval !== 1'b1 || bus.ocos !== POS || bus.osin !== 19'sd0 || bus.otab_cos_addr !== 9'd511 || bus.otab_sin_addr !== 9'd0 || bus.otab_clkena !== 1'b0 || bus.oreq_rdy !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL clkena_freeze[%0d]: val %0b %0d/%0d addr %0d/%0d clkena %0b rdy %b", n, bus.oval, bus.ocos, bus.osin, bus.otab_cos_addr, bus.otab_sin_addr, bus.otab_clkena, bus.oreq_rdy);
         end
         tick();
      end
      iclkena = 1'b1;
      applyStimulus(2'b00, 11'h000, 11'h000);
      repeat (8) tick();
      compared++;
      if (outCosQ.size() != 4) begin
         mismatched++;
         $display("[TB] FAIL clkena_count: got %0d results want 4", outCosQ.size());
      end else if (outCosQ[0] !== POS || outSinQ[0] !== 19'sd0 || outCosQ[1] !== 19'sd0 || outSinQ[1] !== POS || outCosQ[2] !== NEG || outSinQ[2] !== 19'sd0 || outCosQ[3] !== 19'sd0 || outSinQ[3] !== NEG) begin
         mismatched++;
         $display("[TB] FAIL clkena_order: got %0d/%0d %0d/%0d %0d/%0d %0d/%0d", outCosQ[0], outSinQ[0], outCosQ[1], outSinQ[1], outCosQ[2], outSinQ[2], outCosQ[3], outSinQ[3]);
      end
`ifdef GAUS_CORDIC_SCHED_STAT_EN
      compared++; if (ostat_grant !== {16'd0, 16'd4} || ostat_stall !== 16'd0) begin mismatched++; $display("[TB] FAIL clkena_stats: grant %h stall %0d want 00000004 0", ostat_grant, ostat_stall); end
`endif
   endtask

   initial begin
      bus.iready     = 1'b1;
      bus.ireq_val   = '0;
      bus.ireq_phase = '0;
      test_reset();
      test_single();
      test_quadrant();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_clkena();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
